// File: rtl/instr_loader_if.sv
// Byte-stream, instruction-memory write and status signals of the loader.
// The slave modport is the loader itself; the master side feeds bytes and
// observes the memory writes and status outputs.
interface instr_loader_if;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        mem_we;
  logic [4:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_rst;
  logic        done;
  logic        err;

  modport master (
    output start, byte_in, byte_valid,
    input  byte_ready, mem_we, mem_addr, mem_wdata, cpu_rst, done, err
  );

  modport slave (
    input  start, byte_in, byte_valid,
    output byte_ready, mem_we, mem_addr, mem_wdata, cpu_rst, done, err
  );
endinterface

// File: rtl/instr_loader.sv
// Instruction loader: receives a count byte, 4*N data bytes (MSB first per
// word) and an XOR checksum byte, writing each completed word to instruction
// memory while holding the core in reset.
module instr_loader #(
  parameter int MAX_WORDS = 32
) (
  input  logic          clk,
  input  logic          rst,
  instr_loader_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    COUNT,
    DATA,
    CHECK,
    DONE,
    ERROR
  } state_t;

  state_t      state_reg, state_next;
  logic [5:0]  cnt_reg, cnt_next;
  logic [4:0]  word_idx_reg, word_idx_next;
  logic [1:0]  byte_idx_reg, byte_idx_next;
  logic [7:0]  csum_reg, csum_next;
  logic [31:0] asm_reg, asm_next;
  logic        mem_we_reg, mem_we_next;
  logic [4:0]  mem_addr_reg, mem_addr_next;
  logic [31:0] mem_wdata_reg, mem_wdata_next;
  logic        accept;

  // Status and handshake outputs decode straight from the state register.
  always_comb begin
    bus.byte_ready = (state_reg == COUNT) || (state_reg == DATA) || (state_reg == CHECK);
    bus.cpu_rst    = (state_reg == COUNT) || (state_reg == DATA) ||
                     (state_reg == CHECK) || (state_reg == ERROR);
    bus.done       = (state_reg == DONE);
    bus.err        = (state_reg == ERROR);
    bus.mem_we     = mem_we_reg;
    bus.mem_addr   = mem_addr_reg;
    bus.mem_wdata  = mem_wdata_reg;
  end

  assign accept = bus.byte_valid && bus.byte_ready;

  // Next-state and datapath updates; everything holds unless a byte is taken.
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    word_idx_next  = word_idx_reg;
    byte_idx_next  = byte_idx_reg;
    csum_next      = csum_reg;
    asm_next       = asm_reg;
    mem_we_next    = 1'b0;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;

    case (state_reg)
      IDLE, DONE, ERROR: begin
        if (bus.start) begin
          state_next    = COUNT;
          csum_next     = 8'd0;
          word_idx_next = 5'd0;
          byte_idx_next = 2'd0;
        end
      end
      COUNT: begin
        if (accept) begin
          if (bus.byte_in == 8'd0 || int'(bus.byte_in) > MAX_WORDS) begin
            state_next = ERROR;
          end else begin
            cnt_next   = 6'(bus.byte_in);
            state_next = DATA;
          end
        end
      end
      DATA: begin
        if (accept) begin
          asm_next      = {asm_reg[23:0], bus.byte_in};
          csum_next     = csum_reg ^ bus.byte_in;
          byte_idx_next = byte_idx_reg + 2'd1;
          if (byte_idx_reg == 2'd3) begin
            mem_we_next    = 1'b1;
            mem_addr_next  = word_idx_reg;
            mem_wdata_next = {asm_reg[23:0], bus.byte_in};
            word_idx_next  = word_idx_reg + 5'd1;
            // The last byte of word N-1 moves straight on to the checksum.
            if ({1'b0, word_idx_reg} + 6'd1 == cnt_reg) begin
              state_next = CHECK;
            end
          end
        end
      end
      CHECK: begin
        if (accept) begin
          state_next = (bus.byte_in == csum_reg) ? DONE : ERROR;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and datapath registers; reset wins over start and byte acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= 6'd0;
      word_idx_reg  <= 5'd0;
      byte_idx_reg  <= 2'd0;
      csum_reg      <= 8'd0;
      asm_reg       <= 32'd0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= 5'd0;
      mem_wdata_reg <= 32'd0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      word_idx_reg  <= word_idx_next;
      byte_idx_reg  <= byte_idx_next;
      csum_reg      <= csum_next;
      asm_reg       <= asm_next;
      mem_we_reg    <= mem_we_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader: table of load streams with expected status, plus a
// scoreboard of expected memory writes checked whenever mem_we pulses.
module tb_instr_loader;

  logic clk = 1'b0;
  logic rst;

  instr_loader_if bus ();

  instr_loader #(.MAX_WORDS(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          nbytes;
    logic [95:0] bytes;      // byte k at [95-8k -: 8]
    bit          gap;        // valid low before each byte from index 2 on
    bit          start_mid;  // pulse start alongside byte 3 (must be ignored)
    bit          exp_done;
    bit          exp_err;
  } vec_t;

  vec_t vecs[7];

  logic [36:0] exp_q[$];   // {addr, data}
  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Scoreboard: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                 bus.mem_addr, bus.mem_wdata);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        check("write_addr", {27'd0, bus.mem_addr}, {27'd0, e[36:32]});
        check("write_data", bus.mem_wdata, e[31:0]);
      end
    end
  end

  task automatic check_idle_outputs(input string tag);
    check({tag, "_mem_we"},     {31'd0, bus.mem_we},     32'd0);
    check({tag, "_mem_addr"},   {27'd0, bus.mem_addr},   32'd0);
    check({tag, "_mem_wdata"},  bus.mem_wdata,           32'd0);
    check({tag, "_cpu_rst"},    {31'd0, bus.cpu_rst},    32'd0);
    check({tag, "_done"},       {31'd0, bus.done},       32'd0);
    check({tag, "_err"},        {31'd0, bus.err},        32'd0);
    check({tag, "_byte_ready"}, {31'd0, bus.byte_ready}, 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    int cnt;
    int nw;
    // Expected writes come from the stream itself: each complete word of a
    // load whose count byte is legal.
    cnt = int'(v.bytes[95 -: 8]);
    if (cnt >= 1 && cnt <= 32) begin
      nw = (v.nbytes - 1) / 4;
      if (nw > cnt) nw = cnt;
      for (int w = 0; w < nw; w++)
        exp_q.push_back({5'(w), v.bytes[95 - 8 * (1 + 4 * w) -: 32]});
    end

    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    check({v.name, "_count_ready"}, {31'd0, bus.byte_ready}, 32'd1);
    check({v.name, "_count_cpurst"}, {31'd0, bus.cpu_rst}, 32'd1);
    check({v.name, "_count_done"}, {31'd0, bus.done}, 32'd0);
    check({v.name, "_count_err"}, {31'd0, bus.err}, 32'd0);

    for (int k = 0; k < v.nbytes; k++) begin
      if (v.gap && k >= 2) begin
        bus.byte_valid = 1'b0;
        bus.byte_in    = 8'($urandom);
        @(negedge clk);
        check({v.name, "_gap_ready"}, {31'd0, bus.byte_ready}, 32'd1);
      end
      bus.byte_in    = v.bytes[95 - 8 * k -: 8];
      bus.byte_valid = 1'b1;
      bus.start      = v.start_mid && (k == 3);
      @(negedge clk);
    end
    bus.byte_valid = 1'b0;
    bus.start      = 1'b0;

    check({v.name, "_done"}, {31'd0, bus.done}, {31'd0, v.exp_done});
    check({v.name, "_err"}, {31'd0, bus.err}, {31'd0, v.exp_err});
    check({v.name, "_cpu_rst"}, {31'd0, bus.cpu_rst}, {31'd0, v.exp_err});
    check({v.name, "_ready_low"}, {31'd0, bus.byte_ready}, 32'd0);
    check({v.name, "_writes_drained"}, 32'(exp_q.size()), 32'd0);
    // Final state must hold until the next start.
    repeat (3) @(negedge clk);
    check({v.name, "_hold_cpu_rst"}, {31'd0, bus.cpu_rst}, {31'd0, v.exp_err});
    check({v.name, "_hold_err"}, {31'd0, bus.err}, {31'd0, v.exp_err});
    check({v.name, "_hold_done"}, {31'd0, bus.done}, {31'd0, v.exp_done});
    $display("load %s: done=%b err=%b cpu_rst=%b", v.name, bus.done, bus.err, bus.cpu_rst);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete, expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{"one_word",    6,  96'h011234567808_000000000000, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{"two_words",   10, 96'h02_20080005_00000000_2D_0000, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{"count_zero",  1,  96'h0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{"count_33",    1,  96'h21_0000000000000000000000, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{"bad_csum",    6,  96'h011234567800_000000000000, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{"gapped_one",  6,  96'h011234567808_000000000000, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{"gapped_two",  10, 96'h02_DEADBEEF_01020304_26_0000, 1'b1, 1'b0, 1'b1, 1'b0};

    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.byte_in    = 8'd0;
    bus.byte_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Reset mid-load after two data bytes, with start and a valid byte
    // presented in the same cycle.
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) begin
      bus.start      = 1'b0;
      bus.byte_in    = 8'h01;
      bus.byte_valid = 1'b1;
    end
    @(negedge clk) bus.byte_in = 8'h12;
    @(negedge clk) bus.byte_in = 8'h34;
    @(negedge clk) begin
      rst            = 1'b1;
      bus.start      = 1'b1;
      bus.byte_in    = 8'h56;
      bus.byte_valid = 1'b1;
    end
    @(negedge clk) begin
      rst            = 1'b0;
      bus.start      = 1'b0;
      bus.byte_valid = 1'b0;
    end
    check_idle_outputs("midload_rst");
    check("midload_rst_no_writes", 32'(exp_q.size()), 32'd0);
    $display("load midload_rst: done=%b err=%b cpu_rst=%b", bus.done, bus.err, bus.cpu_rst);
    @(negedge clk);
    check_idle_outputs("midload_rst_idle");
    vecs[0].name = "after_rst";
    run_vec(vecs[0]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 The module SHALL have parameter MAX_WORDS, default 32, giving the maximum number of 32-bit words per load (5-bit word address space).
REQ-002 The module SHALL have port clk, input, 1, the single clock; all state updates occur on the rising edge.
REQ-003 The module SHALL have port rst, input, 1, the synchronous active-high reset.
REQ-004 The module SHALL have port start, input, 1, a one-cycle request to begin a load.
REQ-005 The module SHALL have port byte_in, input, 8, the incoming stream byte.
REQ-006 The module SHALL have port byte_valid, input, 1, asserted when byte_in holds a byte.
REQ-007 The module SHALL have port byte_ready, output, 1, asserted when the loader can accept a byte; a byte is accepted when byte_valid and byte_ready are both high on a clock edge.
REQ-008 The module SHALL have port mem_we, output, 1, the instruction-memory write strobe.
REQ-009 The module SHALL have port mem_addr, output, 5, the instruction-memory word address.
REQ-010 The module SHALL have port mem_wdata, output, 32, the instruction-memory write data.
REQ-011 The module SHALL have port cpu_rst, output, 1, which holds the processor core in reset while a load is in progress.
REQ-012 The module SHALL have port done, output, 1, asserted when a load completed with a good checksum.
REQ-013 The module SHALL have port err, output, 1, asserted when a load failed.

Function
REQ-014 The state machine SHALL have the states IDLE, COUNT, DATA, CHECK, DONE and ERROR.
REQ-015 The stream format SHALL be: a count byte N, then 4*N data bytes sent MSB first within each word, then one checksum byte equal to the XOR of all data bytes; the count byte is excluded from the checksum.
REQ-016 A start pulse in IDLE, DONE or ERROR SHALL move the machine to COUNT, clear done and err, and clear the checksum accumulator, word index and byte index.
REQ-017 A start pulse in COUNT, DATA or CHECK SHALL be ignored.
REQ-018 byte_ready SHALL be 1 exactly in COUNT, DATA and CHECK, decoded directly from the state register.
REQ-019 When a count byte is accepted in COUNT, a value of 0 or a value greater than MAX_WORDS SHALL send the machine to ERROR; otherwise the machine SHALL latch N and go to DATA.
REQ-020 In DATA, each accepted byte SHALL be shifted into a 32-bit assembly register as {asm[23:0], byte_in}, XORed into the checksum, and SHALL increment the 2-bit byte index, which wraps from 3 to 0.
REQ-021 On acceptance of the 4th byte of a word, mem_we SHALL be 1 in the following cycle only, with mem_addr equal to the word index and mem_wdata equal to the completed word.
REQ-022 After that write, the word index SHALL increment; the machine SHALL go to CHECK on the edge that accepts the last byte of word N-1.
REQ-023 In DATA, cycles with byte_valid low SHALL hold all state, with no timeout.
REQ-024 In CHECK, an accepted byte equal to the checksum SHALL send the machine to DONE; any other value SHALL send it to ERROR.
REQ-025 cpu_rst SHALL be 1 in COUNT, DATA, CHECK and ERROR, and 0 in IDLE and DONE.
REQ-026 done SHALL be 1 only in DONE, and err SHALL be 1 only in ERROR.
REQ-027 Outside write cycles, mem_we SHALL be 0, while mem_addr and mem_wdata hold their last values.
REQ-028 Words already written before an ERROR SHALL remain in memory; no rollback is performed.

Reset
REQ-029 When rst is high on a clock edge, the module SHALL enter IDLE regardless of state, including mid-load.
REQ-030 On that reset, mem_we, mem_addr, mem_wdata, cpu_rst, done, err, the checksum, the indices and the assembly register SHALL all be set to 0.
REQ-031 rst SHALL take priority over start and over byte acceptance in the same cycle.

Verification
REQ-032 A bench SHALL check: start, then bytes 01, 12,34,56,78, 08 with valid always high -> one mem_we pulse with addr 0 and wdata 0x12345678; done=1; cpu_rst=0.
REQ-033 A bench SHALL check: N=2, words 0x20080005 and 0x00000000, checksum 0x2D -> writes at addr 0 then addr 1; done=1.
REQ-034 A bench SHALL check: count byte 00, and separately count byte 0x21 -> ERROR, err=1, cpu_rst=1, no mem_we.
REQ-035 A bench SHALL check: N=1 with a wrong checksum 0x00 -> the word is still written, err=1, and cpu_rst stays 1 until the next start.
REQ-036 A bench SHALL check: byte_valid toggled every other cycle during DATA -> the same writes occur as with a gapless stream, and byte_ready stays 1 throughout.
REQ-037 A bench SHALL check: rst asserted after 2 data bytes -> the next cycle is IDLE with all outputs 0; a following full load succeeds.
